fetch_unit: RTL and testbench

Instruction fetch stage that drives the address port of the instruction memory and registers the returned word for decode. It holds the program counter and a one-entry fetch register (instruction plus its PC). It also handles taken-branch redirects, back-pressure from decode, and halt handling for the HLT opcode. It sits between the combinational instruction memory and the decode/execute stage.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry fetch register, redirect/stall/halt.
// Define FETCH_PERF_CNT_EN to add fetch_count and stall_count outputs.
module fetch_unit #(
  parameter int INSTRUCTION_SIZE = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10,
  parameter logic [3:0] HLT_OPCODE = 4'b0001
) (
  input  logic clk,
  input  logic rst_n,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_data,
  input  logic stall,
  input  logic redirect_valid,
  input  logic [INSTRUCTION_ADDR_SIZE-1:0] redirect_addr,
  input  logic hlt_commit,
  output logic instr_valid,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count,
`endif
  output logic halted
);

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] HALT_PEND = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state;
  logic [INSTRUCTION_ADDR_SIZE-1:0] pc;
  logic live;
  logic is_hlt;
  logic do_hlt;
  logic do_redir;
  logic do_fetch;
  logic do_drain;

  assign imem_addr = pc;
  assign halted = (state == HALTED);
  assign live = (state != HALTED);
  assign is_hlt =
    (imem_data[INSTRUCTION_SIZE-1 -: 4] == HLT_OPCODE);

  // One-hot action select; anything else holds.
  assign do_hlt = live & hlt_commit;
  assign do_redir = live & ~hlt_commit & redirect_valid;
  assign do_fetch = (state == RUN) & ~hlt_commit
                  & ~redirect_valid & ~stall;
  assign do_drain = (state == HALT_PEND) & ~hlt_commit
                  & ~redirect_valid & ~stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= '0;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      unique case (1'b1)
        do_hlt: begin
          state <= HALTED;
          instr_valid <= 1'b0;
        end
        do_redir: begin
          state <= RUN;
          pc <= redirect_addr;
          instr_valid <= 1'b0;
        end
        do_fetch: begin
          instr <= imem_data;
          instr_pc <= pc;
          instr_valid <= 1'b1;
          if (is_hlt) begin
            state <= HALT_PEND;
          end else begin
            pc <= pc + INSTRUCTION_ADDR_SIZE'(1);
          end
        end
        do_drain: begin
          instr_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (do_fetch) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (stall && live) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Vector-table bench for fetch_unit with a combinational instruction memory.
// Expected outputs are queued as each vector is driven and popped after the edge.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] imem_addr;
  logic [15:0] imem_data;
  logic stall;
  logic redirect_valid;
  logic [9:0] redirect_addr;
  logic hlt_commit;
  logic instr_valid;
  logic [15:0] instr;
  logic [9:0] instr_pc;
  logic halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [1024];

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .hlt_commit(hlt_commit),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count),
    .stall_count(stall_count),
`endif
    .halted(halted)
  );

  typedef struct {
    logic rst_n;
    logic stall;
    logic rv;
    logic [9:0] ra;
    logic hc;
    logic ev;
    logic cd;
    logic [15:0] ei;
    logic [9:0] ep;
    logic [9:0] ea;
    logic eh;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic void add(
    input logic r, input logic s, input logic rv,
    input logic [9:0] ra, input logic hc,
    input logic ev, input logic cd, input logic [15:0] ei,
    input logic [9:0] ep, input logic [9:0] ea, input logic eh);
    vec_t v;
    v.rst_n = r; v.stall = s; v.rv = rv; v.ra = ra; v.hc = hc;
    v.ev = ev; v.cd = cd; v.ei = ei; v.ep = ep; v.ea = ea;
    v.eh = eh;
    vecs.push_back(v);
  endfunction

  task automatic check(input int idx);
    vec_t e;
    logic bad;
    e = exp_q.pop_front();
    n_tests++;
    bad = (instr_valid !== e.ev) || (imem_addr !== e.ea)
       || (halted !== e.eh)
       || (e.cd && ((instr !== e.ei) || (instr_pc !== e.ep)));
    if (bad) begin
      n_fail++;
      $display("FAIL vec%0d: got v=%b i=%h pc=%h a=%h h=%b, want v=%b i=%h pc=%h a=%h h=%b (data %s)",
        idx, instr_valid, instr, instr_pc, imem_addr, halted,
        e.ev, e.ei, e.ep, e.ea, e.eh, e.cd ? "checked" : "ignored");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h3000 | 16'(i);
    mem[1] = 16'h8101;
    mem[5] = 16'h2123;
    mem[12] = 16'h1000;

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; hlt_commit = 1'b0;

    // reset state
    add(0,0,0,0,0, 0,1,16'h0,0,0,0);
    // sequential run 0..5
    add(1,0,0,0,0, 1,1,16'h3000,0,1,0);
    add(1,0,0,0,0, 1,1,16'h8101,1,2,0);
    add(1,0,0,0,0, 1,1,16'h3002,2,3,0);
    add(1,0,0,0,0, 1,1,16'h3003,3,4,0);
    add(1,0,0,0,0, 1,1,16'h3004,4,5,0);
    add(1,0,0,0,0, 1,1,16'h2123,5,6,0);
    // stall 3 cycles
    add(1,1,0,0,0, 1,1,16'h2123,5,6,0);
    add(1,1,0,0,0, 1,1,16'h2123,5,6,0);
    add(1,1,0,0,0, 1,1,16'h2123,5,6,0);
    add(1,0,0,0,0, 1,1,16'h3006,6,7,0);
    for (int p = 7; p <= 11; p++)
      add(1,0,0,0,0, 1,1,16'h3000|16'(p),10'(p),10'(p+1),0);
    // redirect to 5 while PC=12 holds HLT
    add(1,0,1,5,0, 0,0,16'h0,0,5,0);
    add(1,0,0,0,0, 1,1,16'h2123,5,6,0);
    for (int p = 6; p <= 11; p++)
      add(1,0,0,0,0, 1,1,16'h3000|16'(p),10'(p),10'(p+1),0);
    // HLT fetched, drains, commits, then ignores inputs
    add(1,0,0,0,0, 1,1,16'h1000,12,12,0);
    add(1,0,0,0,0, 0,0,16'h0,0,12,0);
    add(1,0,0,0,0, 0,0,16'h0,0,12,0);
    add(1,0,0,0,1, 0,0,16'h0,0,12,1);
    add(1,0,1,5,0, 0,0,16'h0,0,12,1);
    add(1,1,0,0,0, 0,0,16'h0,0,12,1);
    // reset, then PC wrap
    add(0,0,0,0,0, 0,1,16'h0,0,0,0);
    add(1,0,1,10'h3FF,0, 0,0,16'h0,0,10'h3FF,0);
    add(1,0,0,0,0, 1,1,16'h33FF,10'h3FF,0,0);
    add(1,0,0,0,0, 1,1,16'h3000,0,1,0);
    // hlt_commit and redirect together in HALT_PEND
    add(1,0,1,12,0, 0,0,16'h0,0,12,0);
    add(1,0,0,0,0, 1,1,16'h1000,12,12,0);
    add(1,0,1,5,1, 0,0,16'h0,0,12,1);
    add(0,1,1,7,0, 0,1,16'h0,0,0,0);
    add(1,0,0,0,0, 1,1,16'h3000,0,1,0);
    // speculative HLT squashed by redirect
    add(1,0,1,12,0, 0,0,16'h0,0,12,0);
    add(1,0,0,0,0, 1,1,16'h1000,12,12,0);
    add(1,0,0,0,0, 0,0,16'h0,0,12,0);
    add(1,0,1,1,0, 0,0,16'h0,0,1,0);
    add(1,0,0,0,0, 1,1,16'h8101,1,2,0);
    // redirect wins over stall
    add(1,1,1,7,0, 0,0,16'h0,0,7,0);
    add(1,0,0,0,0, 1,1,16'h3007,7,8,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check(i - 1);
      rst_n = vecs[i].rst_n;
      stall = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_addr = vecs[i].ra;
      hlt_commit = vecs[i].hc;
      exp_q.push_back(vecs[i]);
    end
    @(negedge clk);
    check(vecs.size() - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
